// File: rtl/transaction_engine_if.sv
// Bundle for the start/finished handshake, amount/key registers and the balance RAM port.
interface transaction_engine_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start_transaction;
  logic [WIDTH-1:0] amount;
  logic [3:0]       key;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             busy;
  logic             anim_active;
  logic             tx_ok;
  logic             tx_reject;
  logic             finished_transaction;

  // System side: main controller, amount/key registers and the RAM read port.
  modport master (
    output start_transaction,
    output amount,
    output key,
    output mem_rdata,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  busy,
    input  anim_active,
    input  tx_ok,
    input  tx_reject,
    input  finished_transaction
  );

  // Engine side.
  modport slave (
    input  start_transaction,
    input  amount,
    input  key,
    input  mem_rdata,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output busy,
    output anim_active,
    output tx_ok,
    output tx_reject,
    output finished_transaction
  );

endinterface

// File: rtl/transaction_engine.sv
// Transaction engine: reads both balances, checks funds/overflow, commits or
// rejects, then holds for an animation window and pulses finished_transaction.
// Optional macro TX_FEE_EN: sender additionally pays FEE, which is burned.
module transaction_engine #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     ANIM_CYCLES = 25000000,
  parameter logic [WIDTH-1:0] FEE        = WIDTH'(1)
) (
  input  logic                clock,
  input  logic                resetn,
  transaction_engine_if.slave bus
);

  localparam int unsigned     CNT_W    = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ANIM_CYCLES - 1);

`ifdef TX_FEE_EN
  localparam logic [WIDTH:0] FEE_NEED = {1'b0, FEE};
`else
  localparam logic [WIDTH:0] FEE_NEED = '0;
  logic unused_fee;
  assign unused_fee = ^FEE;
`endif

  typedef enum logic [3:0] {
    IDLE,
    RD_S,
    RD_R,
    LATCH,
    CHECK,
    WR_S,
    WR_R,
    ANIM,
    DONE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_n;

  logic             sender;
  logic             sender_n;
  logic [WIDTH-1:0] amt;
  logic [WIDTH-1:0] amt_n;
  logic [WIDTH-1:0] sbal;
  logic [WIDTH-1:0] sbal_n;
  logic [WIDTH-1:0] rbal;
  logic [WIDTH-1:0] rbal_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  logic             addr_n;
  logic             we_n;
  logic [WIDTH-1:0] wdata_n;
  logic             busy_n;
  logic             anim_n;
  logic             ok_n;
  logic             rej_n;
  logic             fin_n;

  logic [WIDTH:0]   need_c;
  logic [WIDTH:0]   rsum_c;
  logic             reject_c;

  logic             unused_key;
  assign unused_key = ^bus.key[3:1];

  // Funds and overflow checks, both evaluated in WIDTH+1 bits.
  always_comb begin
    need_c   = {1'b0, amt} + FEE_NEED;
    rsum_c   = {1'b0, rbal} + {1'b0, amt};
    reject_c = ({1'b0, sbal} < need_c) || (rsum_c > {1'b0, {WIDTH{1'b1}}});
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, datapath next values and look-ahead outputs for the next state.
  always_comb begin
    state_n  = state;
    sender_n = sender;
    amt_n    = amt;
    sbal_n   = sbal;
    rbal_n   = rbal;
    cnt_n    = cnt;
    ok_n     = bus.tx_ok;
    rej_n    = bus.tx_reject;
    addr_n   = 1'b0;
    we_n     = 1'b0;
    wdata_n  = '0;
    busy_n   = 1'b0;
    anim_n   = 1'b0;
    fin_n    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_transaction) begin
          state_n  = RD_S;
          ok_n     = 1'b0;
          rej_n    = 1'b0;
          amt_n    = bus.amount;
          sender_n = bus.key[0];
        end
      end
      RD_S: begin
        state_n = bus.start_transaction ? RD_R : IDLE;
      end
      RD_R: begin
        if (!bus.start_transaction) begin
          state_n = IDLE;
        end else begin
          sbal_n  = bus.mem_rdata;
          state_n = LATCH;
        end
      end
      LATCH: begin
        if (!bus.start_transaction) begin
          state_n = IDLE;
        end else begin
          rbal_n  = bus.mem_rdata;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (!bus.start_transaction) begin
          state_n = IDLE;
        end else if (reject_c) begin
          rej_n   = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = ANIM;
        end else begin
          ok_n    = 1'b1;
          state_n = WR_S;
        end
      end
      WR_S: begin
        state_n = WR_R;
      end
      WR_R: begin
        cnt_n   = CNT_LOAD;
        state_n = ANIM;
      end
      ANIM: begin
        if (cnt == '0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (!bus.start_transaction) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      RD_S: begin
        addr_n = sender_n;
      end
      RD_R: begin
        addr_n = ~sender_n;
      end
      WR_S: begin
        addr_n  = sender_n;
        we_n    = 1'b1;
        wdata_n = WIDTH'({1'b0, sbal_n} - need_c);
      end
      WR_R: begin
        addr_n  = ~sender_n;
        we_n    = 1'b1;
        wdata_n = WIDTH'(rsum_c);
      end
      default: begin
        addr_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE) && (state_n != HOLD);
    anim_n = (state_n == ANIM);
    fin_n  = (state_n == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sender                   <= 1'b0;
      amt                      <= '0;
      sbal                     <= '0;
      rbal                     <= '0;
      cnt                      <= '0;
      bus.mem_addr             <= 1'b0;
      bus.mem_we               <= 1'b0;
      bus.mem_wdata            <= '0;
      bus.busy                 <= 1'b0;
      bus.anim_active          <= 1'b0;
      bus.tx_ok                <= 1'b0;
      bus.tx_reject            <= 1'b0;
      bus.finished_transaction <= 1'b0;
    end else begin
      sender                   <= sender_n;
      amt                      <= amt_n;
      sbal                     <= sbal_n;
      rbal                     <= rbal_n;
      cnt                      <= cnt_n;
      bus.mem_addr             <= addr_n;
      bus.mem_we               <= we_n;
      bus.mem_wdata            <= wdata_n;
      bus.busy                 <= busy_n;
      bus.anim_active          <= anim_n;
      bus.tx_ok                <= ok_n;
      bus.tx_reject            <= rej_n;
      bus.finished_transaction <= fin_n;
    end
  end

endmodule

// File: tb/tb_transaction_engine.sv
// Directed bench for transaction_engine with a 2-entry synchronous balance RAM model.
module tb_transaction_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ANIM  = 4;
`ifdef TX_FEE_EN
  localparam int FEE_T = 1;
`else
  localparam int FEE_T = 0;
`endif

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  transaction_engine_if #(.WIDTH(WIDTH)) bus ();

  transaction_engine #(
    .WIDTH(WIDTH),
    .ANIM_CYCLES(ANIM),
    .FEE(8'd1)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  // Balance RAM: registered read, write on mem_we; ld is a bench-side preload port.
  logic [7:0] ram [2];
  logic       ld;
  logic       ld_a;
  logic [7:0] ld_d;

  always @(posedge clock) begin
    if (ld) ram[ld_a] <= ld_d;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int total = 0;
  int bad   = 0;
  int lat, wes, anims, fins, hold_busy;
  int w_cyc [2];
  logic       w_addr [2];
  logic [7:0] w_data [2];
  int acc_we, acc_fin, acc_busy;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic a, input logic [7:0] d);
    ld   = 1'b1;
    ld_a = a;
    ld_d = d;
    tick();
    ld   = 1'b0;
  endtask

  // One full handshake: raise start, wait for finished, hold start high, then release.
  task automatic run(input logic [7:0] amt, input logic k);
    lat = 0; wes = 0; anims = 0; fins = 0; hold_busy = 0;
    w_cyc[0] = 0; w_cyc[1] = 0;
    bus.amount = amt;
    bus.key = {3'b101, k};
    bus.start_transaction = 1'b1;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      tick();
      if (bus.mem_we) begin
        if (wes < 2) begin
          w_addr[wes] = bus.mem_addr;
          w_data[wes] = bus.mem_wdata;
          w_cyc[wes]  = i;
        end
        wes++;
      end
      if (bus.anim_active) anims++;
      if (bus.finished_transaction) begin
        fins++;
        lat = i;
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.finished_transaction) fins++;
      if (bus.busy || bus.mem_we) hold_busy++;
    end
    bus.start_transaction = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    ld = 1'b0; ld_a = 1'b0; ld_d = '0;
    resetn = 1'b0;
    bus.start_transaction = 1'b0;
    bus.amount = '0;
    bus.key = '0;
    tick();
    tick();
    chk("reset_outputs",
        {bus.busy, bus.anim_active, bus.tx_ok, bus.tx_reject, bus.finished_transaction,
         bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
    resetn = 1'b1;
    tick();

    // 1: accepted transfer P1 -> P2 of 30
    load(1'b0, 8'd100);
    load(1'b1, 8'd50);
    run(8'd30, 1'b0);
    chk("t1_latency", lat, 11);
    chk("t1_writes", wes, 2);
    chk("t1_w0_addr", w_addr[0], 0);
    chk("t1_w0_data", w_data[0], 70 - FEE_T);
    chk("t1_w1_addr", w_addr[1], 1);
    chk("t1_w1_data", w_data[1], 80);
    chk("t1_w0_cycle", w_cyc[0], 5);
    chk("t1_w_consecutive", w_cyc[1] - w_cyc[0], 1);
    chk("t1_anim_cycles", anims, ANIM);
    chk("t1_fin_pulses", fins, 1);
    chk("t1_no_retrigger", hold_busy, 0);
    chk("t1_ok_rej", {bus.tx_ok, bus.tx_reject}, 2'b10);
    chk("t1_ram_p1", ram[0], 70 - FEE_T);
    chk("t1_ram_p2", ram[1], 80);

    // 2: P2 sends 51 with only 50 -> reject
    load(1'b0, 8'd100);
    load(1'b1, 8'd50);
    run(8'd51, 1'b1);
    chk("t2_latency", lat, 9);
    chk("t2_writes", wes, 0);
    chk("t2_anim_cycles", anims, ANIM);
    chk("t2_fin_pulses", fins, 1);
    chk("t2_ok_rej", {bus.tx_ok, bus.tx_reject}, 2'b01);
    chk("t2_ram_p1", ram[0], 100);
    chk("t2_ram_p2", ram[1], 50);

    // 3: receiver overflow at 256, then exact 255 accepted
    load(1'b1, 8'd250);
    run(8'd6, 1'b0);
    chk("t3_ovf_writes", wes, 0);
    chk("t3_ovf_ok_rej", {bus.tx_ok, bus.tx_reject}, 2'b01);
    run(8'd5, 1'b0);
    chk("t3_edge_ok_rej", {bus.tx_ok, bus.tx_reject}, 2'b10);
    chk("t3_ram_p1", ram[0], 95 - FEE_T);
    chk("t3_ram_p2", ram[1], 255);

    // 4: abort in RD_R, then a normal transfer P2 -> P1 of 10
    load(1'b0, 8'd100);
    load(1'b1, 8'd50);
    bus.amount = 8'd10;
    bus.key = 4'b0001;
    bus.start_transaction = 1'b1;
    tick();
    tick();
    chk("t4_busy_in_rd_r", bus.busy, 1);
    bus.start_transaction = 1'b0;
    tick();
    chk("t4_idle_after_abort", bus.busy, 0);
    acc_we = 0; acc_fin = 0; acc_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_we) acc_we++;
      if (bus.finished_transaction) acc_fin++;
      if (bus.busy) acc_busy++;
    end
    chk("t4_abort_quiet", {acc_we[7:0], acc_fin[7:0], acc_busy[7:0]}, 32'd0);
    chk("t4_abort_flags", {bus.tx_ok, bus.tx_reject}, 2'b00);
    chk("t4_abort_ram_p1", ram[0], 100);
    run(8'd10, 1'b1);
    chk("t4_next_latency", lat, 11);
    chk("t4_next_ram_p1", ram[0], 110);
    chk("t4_next_ram_p2", ram[1], 40 - FEE_T);

    // 5: reset during ANIM keeps committed writes
    load(1'b0, 8'd100);
    load(1'b1, 8'd50);
    bus.amount = 8'd30;
    bus.key = 4'b0000;
    bus.start_transaction = 1'b1;
    acc_busy = 0;
    for (int i = 0; i < 30 && !bus.anim_active; i++) begin
      tick();
      acc_busy++;
    end
    chk("t5_reached_anim", bus.anim_active, 1);
    tick();
    resetn = 1'b0;
    bus.start_transaction = 1'b0;
    tick();
    chk("t5_reset_outputs",
        {bus.busy, bus.anim_active, bus.tx_ok, bus.tx_reject, bus.finished_transaction,
         bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
    resetn = 1'b1;
    tick();
    tick();
    chk("t5_idle", {bus.busy, bus.finished_transaction}, 2'b00);
    chk("t5_ram_p1", ram[0], 70 - FEE_T);
    chk("t5_ram_p2", ram[1], 80);

`ifdef TX_FEE_EN
    // 6: fee makes amount=30 unaffordable from 30, amount=29 drains to 0
    load(1'b0, 8'd30);
    load(1'b1, 8'd50);
    run(8'd30, 1'b0);
    chk("t6_fee_reject", {bus.tx_ok, bus.tx_reject}, 2'b01);
    chk("t6_fee_reject_writes", wes, 0);
    run(8'd29, 1'b0);
    chk("t6_fee_ok", {bus.tx_ok, bus.tx_reject}, 2'b10);
    chk("t6_ram_p1", ram[0], 0);
    chk("t6_ram_p2", ram[1], 79);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
